segment_transition: RTL and testbench

- Per-subsystem segment swap controller; one instance for modulation and one for STM.
- Sits between the controller register block (REQ_RD_SEGMENT, REP0/1, TRANSITION_MODE/VALUE) and the index counter.
- Decides when playback switches segment and when finite-repeat playback stops.
- Drives the active segment, a swap pulse that restarts the index counter, and a stop flag.

---
 rtl/segment_transition_pkg.sv | 29 ++
 rtl/segment_transition_cond.sv | 42 ++++
 rtl/segment_transition.sv | 138 +++++++++++++
 tb/tb_segment_transition.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/segment_transition_pkg.sv
// Shared types for the segment transition controller: transition modes,
// FSM states and the repeat-forever marker.
package segment_transition_pkg;

  typedef enum logic [7:0] {
    TRANSITION_MODE_SYNC_IDX = 8'h00,
    TRANSITION_MODE_SYS_TIME = 8'h01,
    TRANSITION_MODE_GPIO     = 8'h02,
    TRANSITION_MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic {
    PLAY      = 1'b0,
    WAIT_COND = 1'b1
  } segment_transition_state_t;

  localparam logic [15:0] RepInfinite = 16'hFFFF;

  function automatic logic mode_is_valid(input logic [7:0] mode);
    case (mode)
      TRANSITION_MODE_SYNC_IDX,
      TRANSITION_MODE_SYS_TIME,
      TRANSITION_MODE_GPIO,
      TRANSITION_MODE_EXT:      mode_is_valid = 1'b1;
      default:                  mode_is_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/segment_transition_cond.sv
// Transition condition evaluator: combinational hit for the latched mode,
// plus the previous-GPIO register used for rising-edge detection.
module transition_cond
  import segment_transition_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_mode,
  input  logic [55:0] i_value,
  input  logic        i_wrap,
  input  logic        i_stop,
  input  logic [55:0] i_sys_time,
  input  logic [3:0]  i_gpio_in,
  output logic        o_hit
);

  logic [3:0] r_gpio_prev;
  logic [3:0] w_gpio_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gpio_prev <= 4'd0;
    end else begin
      r_gpio_prev <= i_gpio_in;
    end
  end

  assign w_gpio_rise = i_gpio_in & ~r_gpio_prev;

  // While stopped no wraps arrive, so index-synchronous modes fire at once.
  always_comb begin
    o_hit = 1'b0;
    case (i_mode)
      TRANSITION_MODE_SYNC_IDX: o_hit = i_wrap | i_stop;
      TRANSITION_MODE_EXT:      o_hit = i_wrap | i_stop;
      TRANSITION_MODE_SYS_TIME: o_hit = (i_sys_time >= i_value);
      TRANSITION_MODE_GPIO:     o_hit = w_gpio_rise[i_value[1:0]];
      default:                  o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_transition.sv
// Segment swap controller: holds a pending segment request, swaps when its
// condition fires, counts loops of the active segment and stops or alternates.
module segment_transition
  import segment_transition_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_segment,
  input  logic [7:0]  i_req_mode,
  input  logic [63:0] i_req_value,
  input  logic [15:0] i_rep0,
  input  logic [15:0] i_rep1,
  input  logic        i_wrap,
  input  logic [55:0] i_sys_time,
  input  logic [3:0]  i_gpio_in,
  output logic        o_segment,
  output logic        o_swap,
  output logic        o_stop,
  output logic        o_busy
);

  segment_transition_state_t r_state, w_state_next;
  logic        r_segment, w_segment_next;
  logic        r_swap, w_swap_next;
  logic        r_stop, w_stop_next;
  logic        r_busy, w_busy_next;
  logic [15:0] r_loop_cnt, w_loop_cnt_next;
  logic        r_ext_active, w_ext_active_next;
  logic        r_pend_seg, w_pend_seg_next;
  logic [7:0]  r_pend_mode, w_pend_mode_next;
  logic [55:0] r_pend_value, w_pend_value_next;

  logic        w_hit;
  logic        w_do_swap;
  logic        w_swap_seg;
  logic [15:0] w_rep;
  logic        w_unused_value_hi;

  assign w_unused_value_hi = ^i_req_value[63:56];
  assign w_rep = r_segment ? i_rep1 : i_rep0;

  transition_cond u_cond (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_mode     (r_pend_mode),
    .i_value    (r_pend_value),
    .i_wrap     (i_wrap),
    .i_stop     (r_stop),
    .i_sys_time (i_sys_time),
    .i_gpio_in  (i_gpio_in),
    .o_hit      (w_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= PLAY;
      r_segment    <= 1'b0;
      r_swap       <= 1'b0;
      r_stop       <= 1'b0;
      r_busy       <= 1'b0;
      r_loop_cnt   <= 16'd0;
      r_ext_active <= 1'b0;
      r_pend_seg   <= 1'b0;
      r_pend_mode  <= 8'd0;
      r_pend_value <= 56'd0;
    end else begin
      r_state      <= w_state_next;
      r_segment    <= w_segment_next;
      r_swap       <= w_swap_next;
      r_stop       <= w_stop_next;
      r_busy       <= w_busy_next;
      r_loop_cnt   <= w_loop_cnt_next;
      r_ext_active <= w_ext_active_next;
      r_pend_seg   <= w_pend_seg_next;
      r_pend_mode  <= w_pend_mode_next;
      r_pend_value <= w_pend_value_next;
    end
  end

  // Priority: a fresh request beats a condition hit, which beats loop counting.
  always_comb begin
    w_state_next      = r_state;
    w_segment_next    = r_segment;
    w_swap_next       = 1'b0;
    w_stop_next       = r_stop;
    w_busy_next       = r_busy;
    w_loop_cnt_next   = r_loop_cnt;
    w_ext_active_next = r_ext_active;
    w_pend_seg_next   = r_pend_seg;
    w_pend_mode_next  = r_pend_mode;
    w_pend_value_next = r_pend_value;
    w_do_swap         = 1'b0;
    w_swap_seg        = r_pend_seg;

    if (i_req_valid) begin
      if (mode_is_valid(i_req_mode)) begin
        w_pend_seg_next   = i_req_segment;
        w_pend_mode_next  = i_req_mode;
        w_pend_value_next = i_req_value[55:0];
        w_ext_active_next = 1'b0;
        w_state_next      = WAIT_COND;
        w_busy_next       = 1'b1;
      end
    end else if (r_state == WAIT_COND && w_hit) begin
      w_do_swap         = 1'b1;
      w_swap_seg        = r_pend_seg;
      w_ext_active_next = (r_pend_mode == TRANSITION_MODE_EXT);
    end else if (r_state == PLAY && i_wrap && w_rep != RepInfinite) begin
      // >= so that lowering REP below the current count still ends the segment.
      if (r_loop_cnt >= w_rep) begin
        if (r_ext_active) begin
          w_do_swap  = 1'b1;
          w_swap_seg = ~r_segment;
        end else begin
          w_stop_next = 1'b1;
        end
      end else begin
        w_loop_cnt_next = r_loop_cnt + 16'd1;
      end
    end

    if (w_do_swap) begin
      w_segment_next  = w_swap_seg;
      w_swap_next     = 1'b1;
      w_loop_cnt_next = 16'd0;
      w_stop_next     = 1'b0;
      w_busy_next     = 1'b0;
      w_state_next    = PLAY;
    end
  end

  assign o_segment = r_segment;
  assign o_swap    = r_swap;
  assign o_stop    = r_stop;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_segment_transition.sv
// Bench for segment_transition: directed scenarios then random traffic,
// every cycle compared against a loop-counting reference model.
module tb_segment_transition;
  import segment_transition_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_segment, i_wrap;
  logic [7:0]  i_req_mode;
  logic [63:0] i_req_value;
  logic [15:0] i_rep0, i_rep1;
  logic [55:0] i_sys_time;
  logic [3:0]  i_gpio_in;
  logic        o_segment, o_swap, o_stop, o_busy;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "reset";

  // reference model state
  bit          m_waiting, m_seg, m_swap, m_stop, m_busy, m_chain, m_pseg;
  int          m_loops;
  logic [7:0]  m_pmode;
  logic [55:0] m_pval;
  logic [3:0]  m_gprev;

  segment_transition dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_segment(i_req_segment),
    .i_req_mode(i_req_mode), .i_req_value(i_req_value),
    .i_rep0(i_rep0), .i_rep1(i_rep1), .i_wrap(i_wrap),
    .i_sys_time(i_sys_time), .i_gpio_in(i_gpio_in),
    .o_segment(o_segment), .o_swap(o_swap), .o_stop(o_stop), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_seg = 0; m_swap = 0; m_stop = 0; m_busy = 0;
    m_chain = 0; m_pseg = 0; m_loops = 0; m_pmode = 0; m_pval = 0; m_gprev = 0;
  endtask

  // One clock of the reference: a segment plays rep+1 loops, then stops or,
  // inside an EXT chain, hands over to the other segment.
  task automatic model_step();
    bit hit, do_sw, sw_seg;
    int rep;
    hit = 0;
    if (m_waiting) begin
      if (m_pmode == TRANSITION_MODE_SYNC_IDX || m_pmode == TRANSITION_MODE_EXT)
        hit = i_wrap || m_stop;
      else if (m_pmode == TRANSITION_MODE_SYS_TIME)
        hit = (i_sys_time >= m_pval);
      else if (m_pmode == TRANSITION_MODE_GPIO)
        hit = i_gpio_in[m_pval[1:0]] && !m_gprev[m_pval[1:0]];
    end
    m_gprev = i_gpio_in;
    m_swap  = 0;
    do_sw   = 0;
    sw_seg  = m_pseg;
    rep     = m_seg ? int'(i_rep1) : int'(i_rep0);
    if (i_req_valid) begin
      if (i_req_mode inside {8'h00, 8'h01, 8'h02, 8'hF0}) begin
        m_pseg = i_req_segment; m_pmode = i_req_mode; m_pval = i_req_value[55:0];
        m_chain = 0; m_waiting = 1; m_busy = 1;
      end
    end else if (hit) begin
      do_sw   = 1;
      m_chain = (m_pmode == TRANSITION_MODE_EXT);
    end else if (!m_waiting && i_wrap && rep != 65535) begin
      if (m_loops + 1 > rep) begin
        if (m_chain) begin do_sw = 1; sw_seg = !m_seg; end
        else m_stop = 1;
      end else begin
        m_loops = m_loops + 1;
      end
    end
    if (do_sw) begin
      m_seg = sw_seg; m_swap = 1; m_loops = 0; m_stop = 0; m_busy = 0; m_waiting = 0;
    end
  endtask

  task automatic check_outputs();
    check("segment", o_segment, m_seg);
    check("swap",    o_swap,    m_swap);
    check("stop",    o_stop,    m_stop);
    check("busy",    o_busy,    m_busy);
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge and compare at the next falling edge.
  task automatic tick(input bit rv, input bit rs, input logic [7:0] rm,
                      input logic [63:0] rval, input bit w);
    i_req_valid = rv; i_req_segment = rs; i_req_mode = rm; i_req_value = rval; i_wrap = w;
    if (rv)
      $display("[%0t] %s req seg=%0d mode=%02h value=%0h t=%0d", $time, phase, rs, rm, rval, i_sys_time);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    i_sys_time = i_sys_time + 56'd1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 8'h00, 64'd0, 0);
  endtask

  initial begin
    logic [55:0] s;
    logic [7:0]  modes [5];
    modes[0] = 8'h00; modes[1] = 8'h01; modes[2] = 8'h02; modes[3] = 8'hF0; modes[4] = 8'h55;

    rst_n = 0; i_req_valid = 0; i_req_segment = 0; i_req_mode = 0; i_req_value = 0;
    i_rep0 = 16'd1; i_rep1 = 16'hFFFF; i_wrap = 0; i_sys_time = 56'd100; i_gpio_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1;

    phase = "finite_rep";
    tick(0, 0, 8'h00, 64'd0, 1);  check("stop_after_wrap1", o_stop, 1'b0);
    idle(1);
    tick(0, 0, 8'h00, 64'd0, 1);  check("stop_after_wrap2", o_stop, 1'b1);
    tick(0, 0, 8'h00, 64'd0, 1);  check("still_seg0", o_segment, 1'b0);

    phase = "sync_idx";
    tick(1, 1, TRANSITION_MODE_SYNC_IDX, 64'd0, 0);  check("busy_set", o_busy, 1'b1);
    tick(0, 0, 8'h00, 64'd0, 0);  check("swap_while_stopped", o_swap, 1'b1);
    check("seg1", o_segment, 1'b1);
    for (int k = 0; k < 4; k++) tick(0, 0, 8'h00, 64'd0, 1);
    check("inf_never_stops", o_stop, 1'b0);
    tick(1, 1, TRANSITION_MODE_SYNC_IDX, 64'd0, 0);
    idle(3);                      check("wait_wrap", o_busy, 1'b1);
    tick(0, 0, 8'h00, 64'd0, 1);  check("swap_on_wrap", o_swap, 1'b1);
    check("busy_clear", o_busy, 1'b0);

    phase = "sys_time";
    i_sys_time = 56'd990;
    tick(1, 0, TRANSITION_MODE_SYS_TIME, 64'd1000, 0);
    for (int k = 0; k < 20; k++) begin
      s = i_sys_time;
      tick(0, 0, 8'h00, 64'd0, 0);
      check("deadline_swap", o_swap, (s == 56'd1000));
    end
    tick(1, 1, TRANSITION_MODE_SYS_TIME, 64'd500, 0);  check("past_not_yet", o_swap, 1'b0);
    tick(0, 0, 8'h00, 64'd0, 0);  check("past_swap", o_swap, 1'b1);

    phase = "gpio";
    i_gpio_in = 4'b0100;
    idle(1);
    tick(1, 0, TRANSITION_MODE_GPIO, 64'd2, 0);
    idle(3);                      check("level_no_fire", o_swap, 1'b0);
    i_gpio_in = 4'b0101; idle(1);
    i_gpio_in = 4'b0100; idle(1); check("other_pin_ignored", o_swap, 1'b0);
    i_gpio_in = 4'b0000; idle(1); check("low", o_swap, 1'b0);
    i_gpio_in = 4'b0100; idle(1); check("rise_fires", o_swap, 1'b1);
    check("seg0", o_segment, 1'b0);

    phase = "ext";
    i_rep0 = 16'd0; i_rep1 = 16'd1;
    tick(1, 1, TRANSITION_MODE_EXT, 64'd0, 0);
    tick(0, 0, 8'h00, 64'd0, 1);  check("ext_swap", o_segment, 1'b1);
    tick(0, 0, 8'h00, 64'd0, 1);  check("seg1_loop1", o_swap, 1'b0);
    idle(1);
    tick(0, 0, 8'h00, 64'd0, 1);  check("auto_to_seg0", o_segment, 1'b0);
    check("auto_swap_pulse", o_swap, 1'b1);
    tick(0, 0, 8'h00, 64'd0, 1);  check("auto_to_seg1", o_segment, 1'b1);
    check("chain_no_stop", o_stop, 1'b0);
    tick(1, 0, TRANSITION_MODE_SYNC_IDX, 64'd0, 0);
    tick(0, 0, 8'h00, 64'd0, 1);  check("cancel_swap", o_segment, 1'b0);
    tick(0, 0, 8'h00, 64'd0, 1);  check("cancel_stops", o_stop, 1'b1);
    check("cancel_no_auto", o_swap, 1'b0);

    phase = "misc";
    tick(1, 1, 8'h55, 64'd0, 0);  check("bad_mode_dropped", o_busy, 1'b0);
    tick(1, 1, TRANSITION_MODE_SYNC_IDX, 64'd0, 0);  check("pending", o_busy, 1'b1);
    tick(1, 1, TRANSITION_MODE_SYS_TIME, 64'hFF_FFFF_FFFF_FFFF, 1);
    check("req_beats_hit", o_swap, 1'b0);
    check("new_pending", o_busy, 1'b1);
    idle(1);                      check("still_waiting", o_segment, 1'b0);
    rst_n = 0;
    #1;
    model_reset();
    check("rst_segment", o_segment, 1'b0);
    check("rst_stop", o_stop, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_swap", o_swap, 1'b0);
    i_gpio_in = 0;
    @(negedge clk);
    rst_n = 1;

    phase = "random";
    i_sys_time = 56'd5000;
    for (int c = 0; c < 4000; c++) begin
      bit          rv, rs, w;
      logic [7:0]  rm;
      logic [63:0] rval;
      rv = ($urandom_range(0, 9) == 0);
      rs = 1'($urandom_range(0, 1));
      rm = modes[$urandom_range(0, 4)];
      rval = {$urandom, $urandom};
      if (rm == TRANSITION_MODE_SYS_TIME)
        rval = {8'd0, i_sys_time + 56'($urandom_range(0, 40)) - 56'd10};
      w = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) i_gpio_in[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0)
        i_rep0 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)
        i_rep1 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
      i_sys_time = i_sys_time + 56'($urandom_range(0, 2));
      tick(rv, rs, rm, rval, w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
